// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider sequencer for the HI/LO file.
// Result is {remainder, quotient}, held until the next operation finishes.
module div_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               div_start_in,
   input  logic               div_signed_in,
   input  logic [WIDTH-1:0]   dividend_in,
   input  logic [WIDTH-1:0]   divisor_in,
   input  logic               flush_in,
   input  logic               div_ack_in,
   output logic               div_busy_out,
   output logic               div_complete_out,
   output logic [2*WIDTH-1:0] div_res_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIXUP,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_signed;
   logic               r_qneg;
   logic               r_rneg;
   logic               r_div0;
   logic [WIDTH-1:0]   r_bmag;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [2*WIDTH-1:0] r_res;

   logic [WIDTH-1:0]   w_amag;
   logic [WIDTH-1:0]   w_bmag;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_trial;
   logic [WIDTH-1:0]   w_qfix;
   logic [WIDTH-1:0]   w_rfix;

   assign w_amag  = (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
   assign w_bmag  = (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;
   // Remainder stays below the divisor, so one extra bit holds the trial sign
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, r_bmag};
   assign w_qfix  = r_qneg ? -r_quo : r_quo;
   assign w_rfix  = r_rneg ? -r_rem : r_rem;

   assign div_busy_out     = (r_state == S_PREP) ||
                             (r_state == S_ITER) ||
                             (r_state == S_FIXUP);
   assign div_complete_out = (r_state == S_DONE);
   assign div_res_out      = r_res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (div_start_in) w_next = S_PREP;
         S_PREP:  w_next = S_ITER;
         S_ITER:  if (r_cnt == LAST) w_next = S_FIXUP;
         S_FIXUP: w_next = S_DONE;
         S_DONE:  if (div_ack_in) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (flush_in) w_next = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_signed <= 1'b0;
         r_qneg   <= 1'b0;
         r_rneg   <= 1'b0;
         r_div0   <= 1'b0;
         r_bmag   <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_res    <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (div_start_in && !flush_in) begin
                  r_a      <= dividend_in;
                  r_b      <= divisor_in;
                  r_signed <= div_signed_in;
               end
            end
            S_PREP: begin
               r_qneg <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
               r_rneg <= r_signed & r_a[WIDTH-1];
               r_div0 <= (r_b == '0);
               r_bmag <= w_bmag;
               r_rem  <= '0;
               r_quo  <= w_amag;
               r_cnt  <= '0;
            end
            S_ITER: begin
               if (!w_trial[WIDTH]) begin
                  r_rem <= w_trial[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b1};
               end else begin
                  r_rem <= w_shift[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b0};
               end
               r_cnt <= r_cnt + CNT_W'(1);
            end
            S_FIXUP: begin
               // A flush here must not leave a result behind for HI/LO
               if (!flush_in) begin
                  if (r_div0) r_res <= {r_a, {WIDTH{1'b1}}};
                  else        r_res <= {w_rfix, w_qfix};
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus random
// operands against an arithmetic reference model.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sgn = 1'b0;
   logic        flush = 1'b0;
   logic        ack = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        comp;
   logic [63:0] res;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] last = '0;

   always #5 clk = ~clk;

   div_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .div_start_in     (start),
      .div_signed_in    (sgn),
      .dividend_in      (a),
      .divisor_in       (b),
      .flush_in         (flush),
      .div_ack_in       (ack),
      .div_busy_out     (busy),
      .div_complete_out (comp),
      .div_res_out      (res)
   );

   function automatic logic [63:0] model(input logic [31:0] x,
                                         input logic [31:0] y,
                                         input logic s);
      longint sx, sy, q, r;
      if (y == 32'd0) return {x, 32'hFFFF_FFFF};
      if (!s) return {x % y, x / y};
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [31:0] x, input logic [31:0] y,
                         input logic s);
      a = x;
      b = y;
      sgn = s;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lat);
      int n;
      n = 0;
      while (!comp && n < 60) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, 64'(n), 64'(lat));
   endtask

   task automatic do_ack(input string tag);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check({tag, "_ackc"}, 64'(comp), 64'd0);
      check({tag, "_ackb"}, 64'(busy), 64'd0);
   endtask

   task automatic run(input string tag, input logic [31:0] x,
                      input logic [31:0] y, input logic s,
                      input logic [63:0] exp);
      launch(x, y, s);
      check({tag, "_busy"}, 64'(busy), 64'd1);
      wait_done(tag, 34);
      check(tag, res, exp);
      last = exp;
      do_ack(tag);
   endtask

   initial begin
      int          seen;
      logic [31:0] x;
      logic [31:0] y;
      logic        s;

      tick();
      tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_comp", 64'(comp), 64'd0);
      check("rst_res", res, 64'd0);
      rst_n = 1'b1;
      tick();

      launch(32'd7, 32'd2, 1'b0);
      check("u7_2_busy", 64'(busy), 64'd1);
      wait_done("u7_2", 34);
      check("u7_2", res, 64'h00000001_00000003);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_comp", 64'(comp), 64'd1);
         check("hold_res", res, 64'h00000001_00000003);
      end
      do_ack("u7_2");

      run("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1,
          64'hFFFFFFFF_FFFFFFFD);
      run("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1,
          64'h00000001_FFFFFFFD);
      run("s_div0", 32'h1234_5678, 32'd0, 1'b1,
          64'h12345678_FFFFFFFF);
      run("u_div0", 32'h1234_5678, 32'd0, 1'b0,
          64'h12345678_FFFFFFFF);
      run("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
          64'h00000000_80000000);
      run("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
          64'h80000000_00000000);

      launch(32'd1000, 32'd3, 1'b0);
      repeat (10) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_busy", 64'(busy), 64'd0);
      check("fl_comp", 64'(comp), 64'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (comp) seen++;
      end
      check("fl_never", 64'(seen), 64'd0);
      check("fl_res", res, last);
      run("u100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E);

      a = 32'd5;
      b = 32'd1;
      start = 1'b1;
      flush = 1'b1;
      tick();
      start = 1'b0;
      flush = 1'b0;
      check("sf_busy0", 64'(busy), 64'd0);
      tick();
      check("sf_busy1", 64'(busy), 64'd0);

      launch(32'd50, 32'd5, 1'b0);
      repeat (5) tick();
      a = 32'd99;
      b = 32'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("sb", 24);
      check("sb_res", res, 64'h00000000_0000000A);
      a = 32'd7;
      b = 32'd2;
      start = 1'b1;
      ack = 1'b1;
      tick();
      start = 1'b0;
      ack = 1'b0;
      check("sa_comp", 64'(comp), 64'd0);
      check("sa_busy", 64'(busy), 64'd0);
      tick();
      check("sa_busy1", 64'(busy), 64'd0);
      check("sa_res", res, 64'h00000000_0000000A);

      for (int i = 0; i < 20; i++) begin
         x = $urandom;
         case ($urandom_range(0, 3))
            0:       y = 32'd0;
            1:       y = 32'($urandom_range(1, 15));
            2:       y = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: y = $urandom;
         endcase
         s = 1'($urandom_range(0, 1));
         run("rnd", x, y, s, model(x, y, s));
      end

      launch(32'd123456, 32'd7, 1'b0);
      repeat (8) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_busy", 64'(busy), 64'd0);
      check("ar_comp", 64'(comp), 64'd0);
      check("ar_res", res, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      run("post_rst", 32'd7, 32'd2, 1'b0, 64'h00000001_00000003);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
